// File: rtl/wishbone_ram_bridge_fsm_pkg.sv
// ============================================================================
// Module : wishbone_ram_bridge_fsm_pkg
// Brief  : Shared FSM encodings, RAM strobe constants and read-latency limits
//          for the Wishbone-to-SRAM bridge (optional macro WB_RAM_BRIDGE_ERR_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wishbone_ram_bridge_fsm_pkg;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_ACK   = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_ISSUE = c_ST_ISSUE,
        ST_WAIT  = c_ST_WAIT,
        ST_ACK   = c_ST_ACK
`ifdef WB_RAM_BRIDGE_ERR_EN
        , ST_ERR = c_ST_ERR
`endif
    } bridge_state_t;

    localparam logic c_CHIP_ENABLE   = 1'b1;
    localparam logic c_CHIP_DISABLE  = 1'b0;
    localparam logic c_WRITE_ENABLE  = 1'b1;
    localparam logic c_WRITE_DISABLE = 1'b0;

    localparam int c_RD_LAT_MIN = 1;
    localparam int c_RD_LAT_MAX = 4;
    localparam int c_CNT_W      = $clog2(c_RD_LAT_MAX) + 1;

endpackage

`default_nettype wire

// File: rtl/wishbone_ram_bridge_fsm_if.sv
// ============================================================================
// Module : wishbone_ram_bridge_fsm_if
// Brief  : Wishbone slave and SRAM master signal bundle for the bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wishbone_ram_bridge_fsm_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int RAM_AW     = 17
);
    logic                  wishbone_cyc_i;
    logic                  wishbone_stb_i;
    logic                  wishbone_we_i;
    logic [ADDR_WIDTH-1:0] wishbone_addr_i;
    logic [DATA_WIDTH-1:0] wishbone_data_i;
    logic [SEL_WIDTH-1:0]  wishbone_sel_i;
    logic [DATA_WIDTH-1:0] wishbone_data_o;
    logic                  wishbone_ack_o;
    logic                  wishbone_err_o;
    logic                  ram_ce_o;
    logic                  ram_we_o;
    logic [RAM_AW-1:0]     ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_data_o;
    logic [SEL_WIDTH-1:0]  ram_sel_o;
    logic [DATA_WIDTH-1:0] ram_data_i;

    // Bridge view
    modport slave (
        input  wishbone_cyc_i, wishbone_stb_i, wishbone_we_i, wishbone_addr_i,
               wishbone_data_i, wishbone_sel_i, ram_data_i,
        output wishbone_data_o, wishbone_ack_o, wishbone_err_o,
               ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, ram_sel_o
    );

    // Bus master plus RAM view
    modport master (
        output wishbone_cyc_i, wishbone_stb_i, wishbone_we_i, wishbone_addr_i,
               wishbone_data_i, wishbone_sel_i, ram_data_i,
        input  wishbone_data_o, wishbone_ack_o, wishbone_err_o,
               ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, ram_sel_o
    );
endinterface

`default_nettype wire

// File: rtl/wb_ram_rdlat_cnt.sv
// ============================================================================
// Module : wb_ram_rdlat_cnt
// Brief  : Loadable saturating down-counter with zero flag for read latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_ram_rdlat_cnt
    import wishbone_ram_bridge_fsm_pkg::*;
#(
    parameter int CNT_W = c_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    input  wire logic             i_dec,
    output logic                  o_done
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == '0);
endmodule

`default_nettype wire

// File: rtl/wishbone_ram_bridge_fsm.sv
// ============================================================================
// Module : wishbone_ram_bridge_fsm
// Brief  : Wishbone B3 classic slave to single-port SRAM bridge, one RAM strobe
//          per transfer; WB_RAM_BRIDGE_ERR_EN adds out-of-window error replies.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wishbone_ram_bridge_fsm
    import wishbone_ram_bridge_fsm_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int                    RAM_AW     = 17,
    parameter int                    RD_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  wire logic                clk,
    input  wire logic                rst,
    wishbone_ram_bridge_fsm_if.slave bus,
    output logic                     busy_o
);
    localparam int c_LAT = (RD_LATENCY < c_RD_LAT_MIN) ? c_RD_LAT_MIN :
                           (RD_LATENCY > c_RD_LAT_MAX) ? c_RD_LAT_MAX : RD_LATENCY;
    localparam logic [c_CNT_W-1:0] c_LAT_LOAD = c_CNT_W'(c_LAT - 1);

    bridge_state_t         r_state, w_state_nxt;
    logic                  r_abort, w_abort_nxt;
    logic                  r_ack, w_ack_nxt;
    logic                  r_ram_ce, w_ram_ce_nxt;
    logic                  r_ram_we, w_ram_we_nxt;
    logic [SEL_WIDTH-1:0]  r_ram_sel, w_ram_sel_nxt;
    logic [RAM_AW-1:0]     r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_data;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_busy;
    logic                  w_latch_req, w_capture, w_cnt_load, w_cnt_dec, w_cnt_done;
    logic                  w_req;
    logic                  w_unused;

    assign w_req    = bus.wishbone_cyc_i & bus.wishbone_stb_i;
    assign w_unused = ^{bus.wishbone_addr_i, BASE_ADDR};

`ifdef WB_RAM_BRIDGE_ERR_EN
    localparam int c_WIN_LSB = RAM_AW + 2;
    logic r_err, w_err_nxt;
    logic w_out_of_win;
    // Window is aligned to its size, so comparing the bits above it suffices
    assign w_out_of_win =
        (bus.wishbone_addr_i[ADDR_WIDTH-1:c_WIN_LSB] != BASE_ADDR[ADDR_WIDTH-1:c_WIN_LSB]) ||
        ((bus.wishbone_addr_i[1:0] != 2'b00) && (&bus.wishbone_sel_i));
`endif

    wb_ram_rdlat_cnt #(
        .CNT_W      (c_CNT_W)
    ) u_rdlat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (c_LAT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_done     (w_cnt_done)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_abort_nxt   = r_abort;
        w_ack_nxt     = 1'b0;
        w_ram_ce_nxt  = c_CHIP_DISABLE;
        w_ram_we_nxt  = c_WRITE_DISABLE;
        w_ram_sel_nxt = '0;
        w_latch_req   = 1'b0;
        w_capture     = 1'b0;
        w_cnt_load    = 1'b0;
        w_cnt_dec     = 1'b0;
`ifdef WB_RAM_BRIDGE_ERR_EN
        w_err_nxt     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_abort_nxt = 1'b0;
                if (w_req) begin
`ifdef WB_RAM_BRIDGE_ERR_EN
                    if (w_out_of_win) begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = 1'b1;
                    end else
`endif
                    begin
                        w_state_nxt   = ST_ISSUE;
                        w_latch_req   = 1'b1;
                        w_ram_ce_nxt  = c_CHIP_ENABLE;
                        w_ram_we_nxt  = bus.wishbone_we_i ? c_WRITE_ENABLE : c_WRITE_DISABLE;
                        w_ram_sel_nxt = bus.wishbone_sel_i;
                    end
                end
            end
            ST_ISSUE: begin
                if (r_ram_we == c_WRITE_ENABLE) begin
                    // The write is already strobed; an abort only drops the ack
                    w_state_nxt = bus.wishbone_cyc_i ? ST_ACK : ST_IDLE;
                    w_ack_nxt   = bus.wishbone_cyc_i;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_load  = 1'b1;
                    w_abort_nxt = r_abort | ~bus.wishbone_cyc_i;
                end
            end
            ST_WAIT: begin
                if (w_cnt_done) begin
                    w_capture = 1'b1;
                    if (r_abort || !bus.wishbone_cyc_i) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACK;
                        w_ack_nxt   = 1'b1;
                    end
                end else begin
                    w_cnt_dec   = 1'b1;
                    w_abort_nxt = r_abort | ~bus.wishbone_cyc_i;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
`ifdef WB_RAM_BRIDGE_ERR_EN
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_abort    <= 1'b0;
            r_ack      <= 1'b0;
            r_ram_ce   <= c_CHIP_DISABLE;
            r_ram_we   <= c_WRITE_DISABLE;
            r_ram_sel  <= '0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_wb_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_abort    <= w_abort_nxt;
            r_ack      <= w_ack_nxt;
            r_ram_ce   <= w_ram_ce_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_ram_sel  <= w_ram_sel_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_latch_req) begin
                r_ram_addr <= bus.wishbone_addr_i[RAM_AW+1:2];
                r_ram_data <= bus.wishbone_data_i;
            end
            if (w_capture) begin
                r_wb_data <= bus.ram_data_i;
            end
        end
    end

`ifdef WB_RAM_BRIDGE_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end
    assign bus.wishbone_err_o = r_err;
`else
    assign bus.wishbone_err_o = 1'b0;
`endif

    assign bus.wishbone_ack_o  = r_ack;
    assign bus.wishbone_data_o = r_wb_data;
    assign bus.ram_ce_o        = r_ram_ce;
    assign bus.ram_we_o        = r_ram_we;
    assign bus.ram_sel_o       = r_ram_sel;
    assign bus.ram_addr_o      = r_ram_addr;
    assign bus.ram_data_o      = r_ram_data;
    assign busy_o              = r_busy;
endmodule

`default_nettype wire

// File: tb/tb_wishbone_ram_bridge_fsm.sv
// ============================================================================
// Module : tb_wishbone_ram_bridge_fsm
// Brief  : Directed bench over five bridge instances (latency 1..4, plus an
//          offset-window instance); honours WB_RAM_BRIDGE_ERR_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wishbone_ram_bridge_fsm;
    logic clk;
    logic rst;

    logic        cyc    [5];
    logic        stb    [5];
    logic        we     [5];
    logic [31:0] adr    [5];
    logic [31:0] wdat   [5];
    logic [3:0]  sel    [5];
    logic [31:0] rdat   [5];
    logic        ack    [5];
    logic        err    [5];
    logic        ce     [5];
    logic        rwe    [5];
    logic [16:0] raddr  [5];
    logic [31:0] rwdata [5];
    logic [3:0]  rsel   [5];
    logic        busy   [5];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 5; k++) begin : g_dut
        localparam int          c_L    = (k < 4) ? k + 1 : 1;
        localparam logic [31:0] c_BASE = (k == 4) ? 32'h1000_0000 : 32'h0;

        logic [31:0] mem  [256];
        logic [31:0] pipe [4];

        wishbone_ram_bridge_fsm_if #(
            .ADDR_WIDTH (32), .DATA_WIDTH (32), .SEL_WIDTH (4), .RAM_AW (17)
        ) bus ();

        wishbone_ram_bridge_fsm #(
            .ADDR_WIDTH (32), .DATA_WIDTH (32), .SEL_WIDTH (4), .RAM_AW (17),
            .RD_LATENCY (c_L), .BASE_ADDR (c_BASE)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .bus    (bus),
            .busy_o (busy[k])
        );

        assign bus.wishbone_cyc_i  = cyc[k];
        assign bus.wishbone_stb_i  = stb[k];
        assign bus.wishbone_we_i   = we[k];
        assign bus.wishbone_addr_i = adr[k];
        assign bus.wishbone_data_i = wdat[k];
        assign bus.wishbone_sel_i  = sel[k];
        assign bus.ram_data_i      = pipe[c_L-1];
        assign rdat[k]   = bus.wishbone_data_o;
        assign ack[k]    = bus.wishbone_ack_o;
        assign err[k]    = bus.wishbone_err_o;
        assign ce[k]     = bus.ram_ce_o;
        assign rwe[k]    = bus.ram_we_o;
        assign raddr[k]  = bus.ram_addr_o;
        assign rwdata[k] = bus.ram_data_o;
        assign rsel[k]   = bus.ram_sel_o;

        // RAM model: word i resets to A5A5A5_ii, read data valid c_L cycles after ce
        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 256; i++) mem[i] <= {24'hA5A5A5, i[7:0]};
            end else if (ce[k] && rwe[k]) begin
                for (int b = 0; b < 4; b++)
                    if (rsel[k][b]) mem[raddr[k][7:0]][8*b +: 8] <= rwdata[k][8*b +: 8];
            end
            pipe[0] <= (ce[k] && !rwe[k]) ? mem[raddr[k][7:0]] : 32'hBADC0DE5;
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer, cycle 0 is the request cycle; counts are relative to it
    task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int ack_c, output int ce_n, output int ce_c,
                        output logic [31:0] info, output logic [31:0] rd);
        ack_c = 0; ce_n = 0; ce_c = 0; info = '0; rd = '0;
        step();
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; wdat[i] = d; sel[i] = s;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (ce[i]) begin
                ce_n++; ce_c = c;
                info = {7'd0, rwe[i], 4'd0, rsel[i], 15'd0, raddr[i][0 +: 1]} | {27'd0, raddr[i][4:0]} << 0;
                info = {rwe[i], 3'd0, rsel[i], 7'd0, raddr[i]};
            end
            if (ack[i]) begin
                ack_c = c; rd = rdat[i];
                break;
            end
        end
        cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
    endtask

    initial begin
        int          ack_c, ce_n, ce_c, nack;
        logic [31:0] info, rd, d1, d2;
        logic [9:0]  ackv, cev, busyv, errv;

        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = '0; wdat[k] = '0; sel[k] = '0;
        end
        step(); step(); step();
        chk("rst_data",  rdat[0], 32'h0);
        chk("rst_ack",   ack[0], 0);
        chk("rst_err",   err[0], 0);
        chk("rst_ce",    ce[0], 0);
        chk("rst_we",    rwe[0], 0);
        chk("rst_addr",  raddr[0], 0);
        chk("rst_wdata", rwdata[0], 0);
        chk("rst_sel",   rsel[0], 0);
        for (int k = 0; k < 5; k++) chk("rst_busy", busy[k], 0);
        rst = 1'b0;

        // L=1 full write: ce at T+1 with addr 0x4, ack at T+2
        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, ack_c, ce_n, ce_c, info, rd);
        chk("wr_ack_cyc", ack_c, 2);
        chk("wr_ce_cyc",  ce_c, 1);
        chk("wr_ce_cnt",  ce_n, 1);
        chk("wr_issue",   info, {1'b1, 3'd0, 4'hF, 7'd0, 17'h4});
        chk("wr_ram_data", rwdata[0], 32'hDEADBEEF);

        xfer(0, 0, 32'h10, 32'h0, 4'hF, ack_c, ce_n, ce_c, info, rd);
        chk("rd1_ack_cyc", ack_c, 3);
        chk("rd1_data",    rd, 32'hDEADBEEF);

        // sel=0 write still strobes and acks, memory untouched, data_o holds
        xfer(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, ack_c, ce_n, ce_c, info, rd);
        chk("wr0_ack_cyc", ack_c, 2);
        chk("wr0_issue",   info, {1'b1, 3'd0, 4'h0, 7'd0, 17'h4});
        step(); step();
        chk("data_hold",   rdat[0], 32'hDEADBEEF);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, ack_c, ce_n, ce_c, info, rd);
        chk("wr0_readback", rd, 32'hDEADBEEF);

        // L=3 read-back and byte write
        xfer(2, 1, 32'h10, 32'hDEADBEEF, 4'hF, ack_c, ce_n, ce_c, info, rd);
        chk("l3_wr_ack_cyc", ack_c, 2);
        xfer(2, 0, 32'h10, 32'h0, 4'hF, ack_c, ce_n, ce_c, info, rd);
        chk("l3_rd_ack_cyc", ack_c, 5);
        chk("l3_rd_ce_cyc",  ce_c, 1);
        chk("l3_rd_ce_cnt",  ce_n, 1);
        chk("l3_rd_data",    rd, 32'hDEADBEEF);
        xfer(2, 1, 32'h10, 32'h0000AB00, 4'b0010, ack_c, ce_n, ce_c, info, rd);
        chk("byte_issue",    info, {1'b1, 3'd0, 4'b0010, 7'd0, 17'h4});
        xfer(2, 0, 32'h10, 32'h0, 4'hF, ack_c, ce_n, ce_c, info, rd);
        chk("byte_rd_data",  rd, 32'hDEADABEF);

        // L=2 back-to-back reads with stb held through the ack
        step();
        cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h10; sel[1] = 4'hF;
        ackv = '0; cev = '0; busyv = '0; nack = 0; d1 = '0; d2 = '0;
        for (int c = 1; c <= 9; c++) begin
            step();
            ackv[c] = ack[1]; cev[c] = ce[1]; busyv[c] = busy[1];
            if (ack[1]) begin
                if (nack == 0) begin d1 = rdat[1]; adr[1] = 32'h14; end
                else d2 = rdat[1];
                nack++;
            end
        end
        cyc[1] = 0; stb[1] = 0;
        chk("b2b_ack_vec",  ackv, 10'h210);
        chk("b2b_ce_vec",   cev, 10'h042);
        chk("b2b_busy_vec", busyv, 10'h3DE);
        chk("b2b_data1",    d1, 32'hA5A5A504);
        chk("b2b_data2",    d2, 32'hA5A5A505);

        // L=4 abort during WAIT
        step();
        cyc[3] = 1; stb[3] = 1; we[3] = 0; adr[3] = 32'h10; sel[3] = 4'hF;
        ackv = '0; cev = '0; busyv = '0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 2) begin cyc[3] = 0; stb[3] = 0; end
            ackv[c] = ack[3]; cev[c] = ce[3]; busyv[c] = busy[3];
        end
        chk("abort_ack_vec",  ackv, 10'h000);
        chk("abort_ce_vec",   cev, 10'h002);
        chk("abort_busy_vec", busyv, 10'h03E);
        xfer(3, 0, 32'h14, 32'h0, 4'hF, ack_c, ce_n, ce_c, info, rd);
        chk("post_abort_ack_cyc", ack_c, 6);
        chk("post_abort_data",    rd, 32'hA5A5A505);

        // Window instance (BASE 0x1000_0000): address below the window
        step();
        cyc[4] = 1; stb[4] = 1; we[4] = 0; adr[4] = 32'h0000_0040; sel[4] = 4'hF;
        ackv = '0; cev = '0; errv = '0;
        for (int c = 1; c <= 6; c++) begin
            step();
            ackv[c] = ack[4]; cev[c] = ce[4]; errv[c] = err[4];
            if (ack[4] || err[4]) begin cyc[4] = 0; stb[4] = 0; end
        end
`ifdef WB_RAM_BRIDGE_ERR_EN
        chk("win_err_vec", errv, 10'h002);
        chk("win_ack_vec", ackv, 10'h000);
        chk("win_ce_vec",  cev, 10'h000);
`else
        chk("win_err_vec", errv, 10'h000);
        chk("win_ack_vec", ackv, 10'h008);
        chk("win_ce_vec",  cev, 10'h002);
`endif
        xfer(4, 0, 32'h1000_0010, 32'h0, 4'hF, ack_c, ce_n, ce_c, info, rd);
        chk("win_in_ack_cyc", ack_c, 3);
        chk("win_in_data",    rd, 32'hA5A5A504);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/wishbone_ram_bridge_fsm.md
Name: wishbone_ram_bridge_fsm

Overview:
Wishbone B3 classic slave to synchronous single-port SRAM master bridge with configurable RAM read latency and a word-address mapping window. It is the next-generation instruction/data RAM bridge between the OpenMIPS Wishbone bus interface and on-chip RAM. The FSM issues exactly one RAM strobe per Wishbone transfer, registers the read data, handles master aborts, and optionally flags out-of-window accesses with an error response.

Parameters:
ADDR_WIDTH, 32, Wishbone byte-address width
DATA_WIDTH, 32, data width; multiple of 8
SEL_WIDTH, DATA_WIDTH/8, byte-select width
RAM_AW, 17, RAM word-address width
RD_LATENCY, 1, RAM cycles from ce to valid ram_data_i; legal range 1..4
BASE_ADDR, 32'h0000_0000, byte base of the RAM window; aligned to 4*2^RAM_AW

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high, one clock
wishbone_cyc_i  in  1  bus cycle
wishbone_stb_i  in  1  strobe
wishbone_we_i  in  1  write enable
wishbone_addr_i  in  ADDR_WIDTH  byte address
wishbone_data_i  in  DATA_WIDTH  write data
wishbone_sel_i  in  SEL_WIDTH  byte selects
wishbone_data_o  out  DATA_WIDTH  registered read data
wishbone_ack_o  out  1  transfer acknowledge
wishbone_err_o  out  1  error response (see Optional Feature)
ram_ce_o  out  1  RAM chip enable
ram_we_o  out  1  RAM write enable
ram_addr_o  out  RAM_AW  RAM word address = wishbone_addr_i[RAM_AW+1:2]
ram_data_o  out  DATA_WIDTH  RAM write data
ram_sel_o  out  SEL_WIDTH  RAM byte enables
ram_data_i  in  DATA_WIDTH  RAM read data
busy_o  out  1  FSM not in IDLE

Behaviour:
- All outputs are registered. Reset clears every output to 0, including data_o and ram_addr_o. FSM state goes to IDLE and the latency counter goes to 0.
- FSM states are IDLE, ISSUE, WAIT, ACK, ERR.
- IDLE: if cyc&stb in cycle T, latch we/addr/data/sel into the ram_* registers and go to ISSUE.
- ISSUE (cycle T+1): ram_ce_o=1 for exactly this cycle; ram_we_o=we.
  - Write: go to ACK.
  - Read: load the counter with RD_LATENCY-1 and go to WAIT.
- WAIT: decrement the counter. When the counter is 0, capture ram_data_i into wishbone_data_o and go to ACK. ram_data_i is therefore sampled at the end of cycle T+1+RD_LATENCY.
- ACK: wishbone_ack_o=1 for exactly one cycle, then go to IDLE.
  - Write ack is in cycle T+2.
  - Read ack is in cycle T+2+RD_LATENCY.
- Back-to-back: if stb stays high in the ACK cycle, it is sampled again in IDLE the following cycle. Each transfer has exactly one IDLE cycle between transfers; no pipelining.
- Master abort: if cyc=0 in ISSUE or WAIT, the RAM access still completes internally, so no partial strobe occurs. The ack is suppressed and the FSM returns to IDLE after the capture point. Write data already strobed stays committed.
- wishbone_data_o holds its last captured value until the next read capture; it is not cleared after the ack.
- ram_ce_o, ram_we_o and ram_sel_o are 0 in all states except ISSUE. ram_addr_o and ram_data_o hold their last values.
- sel=0 on a write issues the RAM strobe with all byte enables low and still acks.
- Reset asserted in any state overrides everything at the next edge. No ack or err is produced for the interrupted transfer.

Optional Feature:
Macro: WB_RAM_BRIDGE_ERR_EN
- Defined: in IDLE, a request is out of window if addr < BASE_ADDR or addr >= BASE_ADDR + 4*2^RAM_AW, or if addr[1:0] != 0 with sel all-ones.
  - An out-of-window request goes to ERR. No RAM strobe is issued.
  - wishbone_err_o=1 for one cycle at T+1, then the FSM returns to IDLE. ack and err are never both high.
- Undefined: wishbone_err_o is tied 0, the ERR state is not generated, and upper address bits are ignored (the window aliases).

Decomposition:
- Shared package / defines.v holds:
  - the FSM state encodings (3 bits)
  - ChipEnable/ChipDisable and WriteEnable/WriteDisable constants
  - the RD_LATENCY legal range constants
- One natural sub-module: wb_ram_rdlat_cnt. It is the loadable down-counter with done flag, sized $clog2(4)+1 bits.

Test Plan:
- Reset with RD_LATENCY=1: assert rst, check all outputs are 0 and busy_o=0. Write addr 0x10, data 0xDEADBEEF, sel 4'hF at T, then:
  - ram_ce_o=1, ram_we_o=1, ram_addr_o=0x4 at T+1
  - ack=1 at T+2
- Read-back, RD_LATENCY=3: read addr 0x10 at T, RAM model returns 0xDEADBEEF. Check ram_ce_o=1 only at T+1, ack at T+5, data_o=0xDEADBEEF.
- Byte write: sel 4'b0010, data 0x0000AB00 to addr 0x10, then read. Expect 0xDEADABEF. Check ram_sel_o=4'b0010 during ISSUE.
- Back-to-back reads: hold stb high across two reads with RD_LATENCY=2. Expect exactly one IDLE cycle between ack pulses and one ram_ce_o pulse per transfer.
- Abort: drop cyc in the WAIT of a RD_LATENCY=4 read. Expect no ack, busy_o low after the capture cycle, and the next read acks normally.
- With WB_RAM_BRIDGE_ERR_EN, BASE_ADDR=0x1000_0000: read addr 0x0000_0040. Expect err=1 at T+1, ack=0, and no ram_ce_o pulse.
